// File: rtl/onehot_rotator_n.sv
// -----------------------------------------------------------------------------
// onehot_rotator_n
//
// A registered one-hot position register. The active bit can be loaded
// directly, rotated manually left or right, or rotated automatically once
// every period+1 cycles.
//
// Parameters
//   WIDTH    one-hot output width (2..64)
//   STEP_W   width of the rotation-amount input
//   PERIOD_W width of the auto-rotate period input and of the auto counter
//
// Ports
//   clk       single clock, rising-edge active
//   reset     synchronous active-high reset
//   in1       manual rotate-left request (towards MSB)
//   in2       manual rotate-right request (towards LSB)
//   step      positions moved per rotation, applied modulo WIDTH
//   load      load request for load_pos
//   load_pos  target active-bit index
//   auto_en   enable periodic auto-rotation
//   auto_dir  auto direction: 0 = left, 1 = right
//   period    auto tick every period+1 cycles
//   out       registered one-hot vector, out = 1 << pos
//   pos       registered index of the active bit
//   wrap      one-cycle pulse: rotation crossed the WIDTH-1/0 boundary
//   load_err  one-cycle pulse: load_pos was out of range and was rejected
// -----------------------------------------------------------------------------
module onehot_rotator_n #(
  parameter  int WIDTH    = 8,
  parameter  int STEP_W   = 3,
  parameter  int PERIOD_W = 4,
  localparam int POS_W    = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in1,
  input  logic                in2,
  input  logic [STEP_W-1:0]   step,
  input  logic                load,
  input  logic [POS_W-1:0]    load_pos,
  input  logic                auto_en,
  input  logic                auto_dir,
  input  logic [PERIOD_W-1:0] period,
  output logic [WIDTH-1:0]    out,
  output logic [POS_W-1:0]    pos,
  output logic                wrap,
  output logic                load_err
);

  localparam logic [31:0] WIDTH_U = 32'(WIDTH);

  logic [POS_W-1:0]    pos_q, pos_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  logic [31:0]         eff_step;
  logic [31:0]         pos_ext;
  logic [31:0]         left_sum;
  logic [POS_W-1:0]    left_pos, right_pos;
  logic                left_wrap, right_wrap;
  logic                manual;
  logic                auto_tick;

  assign manual    = in1 | in2;
  assign auto_tick = auto_en && (cnt_q == period);

  // Both rotation candidates are computed every cycle in 32-bit arithmetic so
  // that pos + s never overflows before the modulo correction. With s < WIDTH a
  // single conditional subtract/add is enough, and s = 0 can never wrap.
  always_comb begin
    eff_step   = 32'(step) % WIDTH_U;
    pos_ext    = 32'(pos_q);
    left_sum   = pos_ext + eff_step;
    left_wrap  = left_sum >= WIDTH_U;
    left_pos   = POS_W'(left_wrap ? left_sum - WIDTH_U : left_sum);
    right_wrap = pos_ext < eff_step;
    right_pos  = POS_W'(right_wrap ? pos_ext + WIDTH_U - eff_step
                                   : pos_ext - eff_step);
  end

  // Priority: load > manual > auto tick. Any load or manual action clears the
  // auto counter, which also discards a coincident auto tick.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pos_d      = pos_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    cnt_d      = cnt_q;

    if (load) begin
      cnt_d = '0;
      if (32'(load_pos) < WIDTH_U) pos_d = load_pos;
      else                         load_err_d = 1'b1;
    end else if (manual) begin
      cnt_d = '0;
      // in1 & in2 together is a manual hold: counter cleared, pos unchanged.
      if (in1 && !in2) begin
        pos_d  = left_pos;
        wrap_d = left_wrap;
      end else if (!in1 && in2) begin
        pos_d  = right_pos;
        wrap_d = right_wrap;
      end
    end else if (!auto_en) begin
      cnt_d = '0;
    end else if (auto_tick) begin
      cnt_d = '0;
      if (auto_dir) begin
        pos_d  = right_pos;
        wrap_d = right_wrap;
      end else begin
        pos_d  = left_pos;
        wrap_d = left_wrap;
      end
    end else begin
      // A counter already above period (period lowered mid-run) keeps
      // counting and rolls over to 0 before it can match again.
      cnt_d = cnt_q + 1'b1;
    end

    // The one-hot vector is derived from the next position and registered
    // alongside it, so out never has a combinational path from the inputs.
    out_d = {{(WIDTH-1){1'b0}}, 1'b1} << pos_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      pos_q      <= '0;
      out_q      <= {{(WIDTH-1){1'b0}}, 1'b1};
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pos_q      <= pos_d;
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out      = out_q;
  assign pos      = pos_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_onehot_rotator_n.sv
// -----------------------------------------------------------------------------
// tb_onehot_rotator_n
//
// Directed bench for onehot_rotator_n. A WIDTH=8 instance is tracked every
// cycle by an arithmetic position model; a WIDTH=6 instance covers the
// out-of-range load and step-modulo cases with literal expectations.
// -----------------------------------------------------------------------------
module tb_onehot_rotator_n;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- WIDTH = 8 instance ----------------
  logic       reset, in1, in2, load, auto_en, auto_dir;
  logic [2:0] step, load_pos;
  logic [3:0] period;
  logic [7:0] out8;
  logic [2:0] pos8;
  logic       wrap8, err8;

  onehot_rotator_n #(.WIDTH(8), .STEP_W(3), .PERIOD_W(4)) dut8 (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .step(step),
    .load(load), .load_pos(load_pos), .auto_en(auto_en), .auto_dir(auto_dir),
    .period(period), .out(out8), .pos(pos8), .wrap(wrap8), .load_err(err8)
  );

  // ---------------- WIDTH = 6 instance ----------------
  logic       reset6, in1_6, in2_6, load6;
  logic [2:0] step6, load_pos6;
  logic [3:0] period6;
  logic [5:0] out6;
  logic [2:0] pos6;
  logic       wrap6, err6;

  onehot_rotator_n #(.WIDTH(6), .STEP_W(3), .PERIOD_W(4)) dut6 (
    .clk(clk), .reset(reset6), .in1(in1_6), .in2(in2_6), .step(step6),
    .load(load6), .load_pos(load_pos6), .auto_en(1'b0), .auto_dir(1'b0),
    .period(period6), .out(out6), .pos(pos6), .wrap(wrap6), .load_err(err6)
  );

  // ---------------- behavioural model of the WIDTH = 8 instance ----------------
  localparam int W = 8;
  int mpos, mcnt;
  bit mwrap, merr;
  bit model_valid = 1'b0;

  // Move position p by s in the given direction on a ring of W slots.
  function automatic int ring_move(input int p, input int s, input bit right);
    return right ? (p - s + W) % W : (p + s) % W;
  endfunction

  function automatic bit crosses(input int p, input int s, input bit right);
    return right ? (p < s) : (p + s >= W);
  endfunction

  always @(posedge clk) begin
    int s;
    s     = int'(step) % W;
    mwrap = 1'b0;
    merr  = 1'b0;
    if (reset) begin
      mpos = 0;
      mcnt = 0;
    end else if (load) begin
      mcnt = 0;
      if (int'(load_pos) < W) mpos = int'(load_pos);
      else                    merr = 1'b1;
    end else if (in1 || in2) begin
      mcnt = 0;
      if (in1 != in2) begin
        mwrap = crosses(mpos, s, in2);
        mpos  = ring_move(mpos, s, in2);
      end
    end else if (!auto_en) begin
      mcnt = 0;
    end else if (mcnt == int'(period)) begin
      mcnt  = 0;
      mwrap = crosses(mpos, s, auto_dir);
      mpos  = ring_move(mpos, s, auto_dir);
    end else begin
      mcnt = (mcnt + 1) % 16;
    end
  end

  // Compare process: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_pos", 64'(pos8), 64'(mpos));
      check("model_out", 64'(out8), 64'(1) << mpos);
      check("model_wrap", 64'(wrap8), 64'(mwrap));
      check("model_load_err", 64'(err8), 64'(merr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_a[6] = '{0, 0, 1, 1, 1, 2};
  int exp_b[8] = '{0, 0, 1, 1, 0, 0, 0, 1};

  initial begin
    reset = 1'b1; in1 = 1'b1; in2 = 1'b0; step = 3'd1; load = 1'b0;
    load_pos = '0; auto_en = 1'b0; auto_dir = 1'b0; period = '0;
    reset6 = 1'b1; in1_6 = 1'b0; in2_6 = 1'b0; load6 = 1'b0;
    step6 = '0; load_pos6 = '0; period6 = '0;

    // Reset overrides an active in1.
    tick(2);
    check("rst_out", 64'(out8), 64'h01);
    check("rst_pos", 64'(pos8), 64'd0);
    check("rst_wrap", 64'(wrap8), 64'd0);
    check("rst_load_err", 64'(err8), 64'd0);
    model_valid = 1'b1;

    // Eight left rotations by one: wrap only on the eighth.
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      tick(1);
      e = 8'h01 << ((k + 1) % 8);
      check("rotl_out", 64'(out8), 64'(e));
      check("rotl_wrap", 64'(wrap8), 64'(k == 7));
    end

    // Right rotation by 3 from 0 wraps to 5, then 2 without wrap.
    in1 = 1'b0; in2 = 1'b1; step = 3'd3;
    tick(1);
    check("rotr_pos", 64'(pos8), 64'd5);
    check("rotr_out", 64'(out8), 64'h20);
    check("rotr_wrap", 64'(wrap8), 64'd1);
    tick(1);
    check("rotr2_pos", 64'(pos8), 64'd2);
    check("rotr2_out", 64'(out8), 64'h04);
    check("rotr2_wrap", 64'(wrap8), 64'd0);

    // Load beats a coincident manual request.
    in2 = 1'b0; in1 = 1'b1; load = 1'b1; load_pos = 3'd6;
    tick(1);
    check("load_pos", 64'(pos8), 64'd6);
    check("load_out", 64'(out8), 64'h40);
    load = 1'b0;

    // step = 0 holds with no wrap.
    step = 3'd0;
    tick(1);
    check("step0_pos", 64'(pos8), 64'd6);
    check("step0_wrap", 64'(wrap8), 64'd0);
    in1 = 1'b0;

    // Auto run period 2 from pos 0: ticks on edges 3 and 6.
    reset = 1'b1;
    tick(1);
    reset = 1'b0; auto_en = 1'b1; period = 4'd2; auto_dir = 1'b0; step = 3'd1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("auto_pos", 64'(pos8), 64'(exp_a[k]));
    end

    // Same run with a manual right pulse on edge 5 restarting the period.
    reset = 1'b1; auto_en = 1'b0;
    tick(1);
    reset = 1'b0; auto_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in2 = (k == 4);
      tick(1);
      check("auto_manual_pos", 64'(pos8), 64'(exp_b[k]));
    end
    in2 = 1'b0;

    // in1 & in2 holds pos but clears a counter that had reached period.
    tick(2);
    in1 = 1'b1; in2 = 1'b1;
    tick(1);
    check("both_pos", 64'(pos8), 64'd1);
    check("both_wrap", 64'(wrap8), 64'd0);
    in1 = 1'b0; in2 = 1'b0;
    tick(2);
    check("cnt_cleared_pos", 64'(pos8), 64'd1);
    tick(1);
    check("cnt_restart_pos", 64'(pos8), 64'd2);

    // period = 0: a right tick of 5 every cycle, then reset mid-run.
    period = 4'd0; auto_dir = 1'b1; step = 3'd5;
    tick(3);
    reset = 1'b1; in1 = 1'b1;
    tick(1);
    check("midrst_pos", 64'(pos8), 64'd0);
    check("midrst_out", 64'(out8), 64'h01);
    reset = 1'b0; in1 = 1'b0;
    tick(1);
    check("resume_pos", 64'(pos8), 64'd3);
    check("resume_wrap", 64'(wrap8), 64'd1);

    // Lower period below a running count: counter rolls over before matching.
    period = 4'd6;
    tick(5);
    period = 4'd1;
    tick(16);
    auto_en = 1'b0;
    tick(2);

    // ---------------- WIDTH = 6 instance ----------------
    tick(1);
    reset6 = 1'b0; load6 = 1'b1; load_pos6 = 3'd7;
    tick(1);
    check("w6_err_pulse", 64'(err6), 64'd1);
    check("w6_err_pos", 64'(pos6), 64'd0);
    check("w6_err_out", 64'(out6), 64'h01);
    load6 = 1'b0;
    tick(1);
    check("w6_err_clear", 64'(err6), 64'd0);
    load6 = 1'b1; load_pos6 = 3'd5;
    tick(1);
    check("w6_load_pos", 64'(pos6), 64'd5);
    check("w6_load_out", 64'(out6), 64'h20);
    check("w6_load_err", 64'(err6), 64'd0);
    load6 = 1'b0; in1_6 = 1'b1; step6 = 3'd7;  // 7 mod 6 = 1
    tick(1);
    check("w6_mod_pos", 64'(pos6), 64'd0);
    check("w6_mod_out", 64'(out6), 64'h01);
    check("w6_mod_wrap", 64'(wrap6), 64'd1);
    in1_6 = 1'b0; load6 = 1'b1; load_pos6 = 3'd6;
    tick(1);
    check("w6_err_eq_width", 64'(err6), 64'd1);
    check("w6_err_eq_pos", 64'(pos6), 64'd0);
    load6 = 1'b0;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_rotator_n.md
ONEHOT_ROTATOR_N -- requirements
Module: onehot_rotator_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, one-hot output width, legal range 2..64.
REQ-002 The block SHALL have parameter STEP_W, default 3, width of the rotation-amount input.
REQ-003 The block SHALL have parameter PERIOD_W, default 4, width of the auto-rotate period input.
REQ-004 The block SHALL derive localparam POS_W = max(1, ceil(log2(WIDTH))).
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in1  in  1  manual rotate-left request (towards MSB).
REQ-008 in2  in  1  manual rotate-right request (towards LSB).
REQ-009 step  in  STEP_W  positions moved per rotation, applied modulo WIDTH.
REQ-010 load  in  1  load request for load_pos.
REQ-011 load_pos  in  POS_W  target active-bit index.
REQ-012 auto_en  in  1  enable periodic auto-rotation.
REQ-013 auto_dir  in  1  auto direction: 0 = left, 1 = right.
REQ-014 period  in  PERIOD_W  auto tick every period+1 cycles.
REQ-015 out  out  WIDTH  registered one-hot vector, out = 1 << pos.
REQ-016 pos  out  POS_W  registered index of the active bit.
REQ-017 wrap  out  1  registered one-cycle pulse, rotation crossed index WIDTH-1/0 boundary.
REQ-018 load_err  out  1  registered one-cycle pulse, load rejected.

Function
REQ-019 All outputs SHALL be registered and update on the same edge the request is sampled (latency 1 edge, no combinational input-to-output path).
REQ-020 out SHALL be exactly one-hot at all times after reset, equal to 1 << pos.
REQ-021 Effective step s SHALL equal step mod WIDTH.
REQ-022 Left rotation SHALL set pos = (pos + s) mod WIDTH; right rotation SHALL set pos = (pos - s) mod WIDTH.
REQ-023 Priority per cycle SHALL be: load > manual (in1 or in2 high) > auto tick.
REQ-024 load with load_pos < WIDTH SHALL set pos = load_pos, wrap = 0.
REQ-025 load with load_pos >= WIDTH SHALL hold pos and pulse load_err for one cycle.
REQ-026 in1 & ~in2 SHALL rotate left; ~in1 & in2 SHALL rotate right; in1 & in2 SHALL hold pos (still counts as a manual action).
REQ-027 wrap SHALL pulse when left pos + s >= WIDTH, or right pos < s; wrap SHALL be 0 when s = 0.
REQ-028 Auto counter (PERIOD_W bits) SHALL be held at 0 while auto_en = 0.
REQ-029 With auto_en = 1, counter == period SHALL produce an auto tick (rotate by s in auto_dir) and clear counter; otherwise counter increments.
REQ-030 Any load or manual action SHALL clear the auto counter; a coincident auto tick SHALL be discarded.
REQ-031 period = 0 SHALL produce an auto tick every cycle.
REQ-032 Changing period while running SHALL take effect on the next compare; counter > period SHALL continue counting and wrap naturally to 0.

Reset
REQ-033 reset = 1 on a rising edge SHALL set pos = 0, out = 1, wrap = 0, load_err = 0, auto counter = 0, overriding all other inputs.
REQ-034 reset asserted mid auto-run or mid manual sequence SHALL discard the pending operation; operation resumes from pos 0 on the first edge with reset = 0.

Verification
REQ-035 Reset (WIDTH=8): assert reset 2 cycles with in1=1 -> out=0x01, pos=0, wrap=0.
REQ-036 in1=1, step=1, 8 cycles -> out 0x02,0x04,..,0x80,0x01; wrap=1 only on 8th edge.
REQ-037 From pos 0, in2=1, step=3 -> pos 5, out 0x20, wrap=1; next edge -> pos 2, out 0x04, wrap=0.
REQ-038 load=1, load_pos=6, in1=1 same cycle -> pos 6, out 0x40; WIDTH=6: load_pos=7 -> pos unchanged, load_err=1 one cycle.
REQ-039 auto_en=1, period=2, auto_dir=0, step=1 from pos 0 -> pos 1 on 3rd edge, pos 2 on 6th; in2 pulse on 5th edge -> pos 0, next tick 3 edges later.
REQ-040 step=0 with in1=1, and in1=in2=1 -> pos held, wrap=0, auto counter cleared.
